// File: rtl/fetch_unit_if.sv
// Handshake and fetch bus between the fetch stage and its neighbours
// (testbench control, decoder, ALU flag, branch LUT, instruction ROM).
interface fetch_unit_if #(
    parameter int PC_W  = 10,
    parameter int CNT_W = 16
);
    logic             Start;
    logic [1:0]       ProgSel;
    logic             BranchEn;
    logic             Taken;
    logic [PC_W-1:0]  Target;
    logic             Ack;
    logic [PC_W-1:0]  ProgCtr;
    logic             Running;
    logic             Done;
    logic [CNT_W-1:0] CycleCount;

    modport master (
        output Start, ProgSel, BranchEn, Taken, Target, Ack,
        input  ProgCtr, Running, Done, CycleCount
    );

    modport slave (
        input  Start, ProgSel, BranchEn, Taken, Target, Ack,
        output ProgCtr, Running, Done, CycleCount
    );
endinterface

// File: rtl/fetch_unit.sv
// Program counter / fetch stage: loads a program entry point, runs one
// instruction per cycle until the decoder acknowledges halt, counts RUN cycles.
module fetch_unit #(
    parameter int PC_W   = 10,
    parameter int CNT_W  = 16,
    parameter int START0 = 0,
    parameter int START1 = 256,
    parameter int START2 = 512
) (
    input  logic         Clk,
    input  logic         Reset,
    fetch_unit_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_HALT = 2'd3
    } state_t;

    localparam logic [PC_W-1:0] ENTRY0 = PC_W'(START0);
    localparam logic [PC_W-1:0] ENTRY1 = PC_W'(START1);
    localparam logic [PC_W-1:0] ENTRY2 = PC_W'(START2);

    state_t           state_r;
    logic [PC_W-1:0]  pc_r;
    logic [CNT_W-1:0] cnt_r;
    logic             running_r;
    logic             done_r;

    // Program select 3 shares the program 2 entry point.
    function automatic logic [PC_W-1:0] entry_addr(input logic [1:0] sel);
        logic [PC_W-1:0] addr;
        case (sel)
            2'd0:    addr = ENTRY0;
            2'd1:    addr = ENTRY1;
            2'd2:    addr = ENTRY2;
            default: addr = ENTRY2;
        endcase
        return addr;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val);
        logic [CNT_W-1:0] res;
        if (val == {CNT_W{1'b1}}) begin
            res = val;
        end else begin
            res = val + CNT_W'(1);
        end
        return res;
    endfunction

    // Fetch FSM: state, program counter, cycle counter and status flags.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_r   <= ST_IDLE;
            pc_r      <= {PC_W{1'b0}};
            cnt_r     <= {CNT_W{1'b0}};
            running_r <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.Start) begin
                        state_r <= ST_LOAD;
                        pc_r    <= entry_addr(bus.ProgSel);
                    end
                end
                ST_LOAD: begin
                    pc_r  <= entry_addr(bus.ProgSel);
                    cnt_r <= {CNT_W{1'b0}};
                    if (!bus.Start) begin
                        state_r   <= ST_RUN;
                        running_r <= 1'b1;
                    end
                end
                ST_RUN: begin
                    // Priority: abort, then halt, then branch, then sequential.
                    if (bus.Start) begin
                        state_r   <= ST_LOAD;
                        running_r <= 1'b0;
                        pc_r      <= entry_addr(bus.ProgSel);
                        cnt_r     <= {CNT_W{1'b0}};
                    end else if (bus.Ack) begin
                        state_r   <= ST_HALT;
                        running_r <= 1'b0;
                        done_r    <= 1'b1;
                        cnt_r     <= sat_inc(cnt_r);
                    end else begin
                        cnt_r <= sat_inc(cnt_r);
                        if (bus.BranchEn && bus.Taken) begin
                            pc_r <= bus.Target;
                        end else begin
                            pc_r <= pc_r + PC_W'(1);
                        end
                    end
                end
                ST_HALT: begin
                    if (bus.Start) begin
                        state_r <= ST_LOAD;
                        done_r  <= 1'b0;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    pc_r      <= {PC_W{1'b0}};
                    cnt_r     <= {CNT_W{1'b0}};
                    running_r <= 1'b0;
                    done_r    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ProgCtr    = pc_r;
    assign bus.CycleCount = cnt_r;
    assign bus.Running    = running_r;
    assign bus.Done       = done_r;

endmodule

// File: tb/tb_fetch_unit.sv
// Table-driven scoreboard bench for fetch_unit, with a second instance at a
// narrow cycle counter to exercise saturation.
module tb_fetch_unit;

    typedef struct {
        string       name;
        logic        rst;
        logic        start;
        logic [1:0]  sel;
        logic        ben;
        logic        tkn;
        logic [9:0]  tgt;
        logic        ack;
        logic [9:0]  pc;
        logic        run;
        logic        done;
        logic [15:0] cnt;
    } vec_t;

    typedef struct {
        string       name;
        logic [9:0]  pc;
        logic        run;
        logic        done;
        logic [15:0] cnt;
    } exp_t;

    logic Clk = 1'b0;
    logic rst1;
    logic rst2;
    int   total = 0;
    int   bad   = 0;
    vec_t vecs[$];
    exp_t sb_q[$];

    always #5 Clk = ~Clk;

    fetch_unit_if #(.PC_W(10), .CNT_W(16)) bus1();
    fetch_unit_if #(.PC_W(10), .CNT_W(4))  bus2();

    fetch_unit #(.PC_W(10), .CNT_W(16), .START0(0), .START1(256), .START2(512))
        dut1 (.Clk(Clk), .Reset(rst1), .bus(bus1));
    fetch_unit #(.PC_W(10), .CNT_W(4), .START0(0), .START1(256), .START2(512))
        dut2 (.Clk(Clk), .Reset(rst2), .bus(bus2));

    task automatic add(input string nm, input logic r, input logic s, input logic [1:0] sel,
                       input logic b, input logic t, input logic [9:0] tg, input logic a,
                       input logic [9:0] pc, input logic run, input logic dn, input logic [15:0] c);
        vec_t v;
        v.name = nm; v.rst = r; v.start = s; v.sel = sel; v.ben = b; v.tkn = t;
        v.tgt = tg; v.ack = a; v.pc = pc; v.run = run; v.done = dn; v.cnt = c;
        vecs.push_back(v);
    endtask

    task automatic expect_out(input string nm, input logic [9:0] pc, input logic run,
                              input logic dn, input logic [15:0] c);
        exp_t e;
        e.name = nm; e.pc = pc; e.run = run; e.done = dn; e.cnt = c;
        sb_q.push_back(e);
    endtask

    task automatic sb_check(input logic [9:0] pc, input logic run, input logic dn,
                            input logic [15:0] c);
        exp_t e;
        total++;
        if (sb_q.size() == 0) begin
            bad++;
            $display("FAIL sb_empty: got pc=%0d with no expected entry", pc);
        end else begin
            e = sb_q.pop_front();
            if (pc !== e.pc || run !== e.run || dn !== e.done || c !== e.cnt) begin
                bad++;
                $display("FAIL %s: got pc=%0d run=%0b done=%0b cnt=%0d, want pc=%0d run=%0b done=%0b cnt=%0d",
                         e.name, pc, run, dn, c, e.pc, e.run, e.done, e.cnt);
            end
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic drive2(input logic s, input logic [1:0] sel, input logic a);
        bus2.Start = s; bus2.ProgSel = sel; bus2.Ack = a;
        bus2.BranchEn = 1'b0; bus2.Taken = 1'b0; bus2.Target = 10'd0;
    endtask

    initial begin
        rst1 = 1'b1;
        rst2 = 1'b1;
        bus1.Start = 1'b0; bus1.ProgSel = 2'd0; bus1.BranchEn = 1'b0;
        bus1.Taken = 1'b0; bus1.Target = 10'd0; bus1.Ack = 1'b0;
        drive2(1'b0, 2'd0, 1'b0);

        //   name            rst  st   sel   ben  tkn  tgt      ack    pc       run  done cnt
        add("reset1",        1'b1,1'b0,2'd0,1'b0,1'b0,10'd0,   1'b0, 10'd0,   1'b0,1'b0,16'd0);
        add("reset2",        1'b1,1'b0,2'd0,1'b0,1'b0,10'd0,   1'b0, 10'd0,   1'b0,1'b0,16'd0);
        add("idle_hold",     1'b0,1'b0,2'd0,1'b0,1'b0,10'd0,   1'b0, 10'd0,   1'b0,1'b0,16'd0);
        add("idle_ignore",   1'b0,1'b0,2'd0,1'b1,1'b1,10'd33,  1'b1, 10'd0,   1'b0,1'b0,16'd0);
        add("load1",         1'b0,1'b1,2'd1,1'b0,1'b0,10'd0,   1'b0, 10'd256, 1'b0,1'b0,16'd0);
        add("load2",         1'b0,1'b1,2'd1,1'b0,1'b0,10'd0,   1'b0, 10'd256, 1'b0,1'b0,16'd0);
        add("load3",         1'b0,1'b1,2'd1,1'b1,1'b1,10'd9,   1'b1, 10'd256, 1'b0,1'b0,16'd0);
        add("to_run",        1'b0,1'b0,2'd1,1'b0,1'b0,10'd0,   1'b0, 10'd256, 1'b1,1'b0,16'd0);
        add("run257",        1'b0,1'b0,2'd1,1'b0,1'b0,10'd0,   1'b0, 10'd257, 1'b1,1'b0,16'd1);
        add("run258",        1'b0,1'b0,2'd1,1'b0,1'b0,10'd0,   1'b0, 10'd258, 1'b1,1'b0,16'd2);
        add("run259",        1'b0,1'b0,2'd1,1'b0,1'b0,10'd0,   1'b0, 10'd259, 1'b1,1'b0,16'd3);
        add("taken_no_ben",  1'b0,1'b0,2'd1,1'b0,1'b1,10'd5,   1'b0, 10'd260, 1'b1,1'b0,16'd4);
        add("halt",          1'b0,1'b0,2'd1,1'b1,1'b1,10'd7,   1'b1, 10'd260, 1'b0,1'b1,16'd5);
        add("halt_hold1",    1'b0,1'b0,2'd1,1'b1,1'b1,10'd9,   1'b1, 10'd260, 1'b0,1'b1,16'd5);
        add("halt_hold2",    1'b0,1'b0,2'd1,1'b0,1'b0,10'd0,   1'b0, 10'd260, 1'b0,1'b1,16'd5);
        add("halt_start",    1'b0,1'b1,2'd2,1'b0,1'b0,10'd0,   1'b0, 10'd260, 1'b0,1'b0,16'd5);
        add("load_sel2",     1'b0,1'b1,2'd2,1'b0,1'b0,10'd0,   1'b0, 10'd512, 1'b0,1'b0,16'd0);
        add("load_sel3",     1'b0,1'b1,2'd3,1'b0,1'b0,10'd0,   1'b0, 10'd512, 1'b0,1'b0,16'd0);
        add("load_sel0",     1'b0,1'b1,2'd0,1'b0,1'b0,10'd0,   1'b0, 10'd0,   1'b0,1'b0,16'd0);
        add("run_entry0",    1'b0,1'b0,2'd0,1'b0,1'b0,10'd0,   1'b0, 10'd0,   1'b1,1'b0,16'd0);
        add("br_to_300",     1'b0,1'b0,2'd0,1'b1,1'b1,10'd300, 1'b0, 10'd300, 1'b1,1'b0,16'd1);
        add("br_taken_40",   1'b0,1'b0,2'd0,1'b1,1'b1,10'd40,  1'b0, 10'd40,  1'b1,1'b0,16'd2);
        add("br_back_300",   1'b0,1'b0,2'd0,1'b1,1'b1,10'd300, 1'b0, 10'd300, 1'b1,1'b0,16'd3);
        add("br_not_taken",  1'b0,1'b0,2'd0,1'b1,1'b0,10'd40,  1'b0, 10'd301, 1'b1,1'b0,16'd4);
        add("br_to_270",     1'b0,1'b0,2'd0,1'b1,1'b1,10'd270, 1'b0, 10'd270, 1'b1,1'b0,16'd5);
        add("abort",         1'b0,1'b1,2'd1,1'b1,1'b1,10'd7,   1'b1, 10'd256, 1'b0,1'b0,16'd0);
        add("rerun",         1'b0,1'b0,2'd1,1'b0,1'b0,10'd0,   1'b0, 10'd256, 1'b1,1'b0,16'd0);
        add("br_to_1023",    1'b0,1'b0,2'd1,1'b1,1'b1,10'd1023,1'b0, 10'd1023,1'b1,1'b0,16'd1);
        add("wrap",          1'b0,1'b0,2'd1,1'b0,1'b0,10'd0,   1'b0, 10'd0,   1'b1,1'b0,16'd2);
        add("run_after_wrap",1'b0,1'b0,2'd1,1'b0,1'b0,10'd0,   1'b0, 10'd1,   1'b1,1'b0,16'd3);
        add("reset_mid",     1'b1,1'b1,2'd2,1'b1,1'b1,10'd99,  1'b1, 10'd0,   1'b0,1'b0,16'd0);
        add("post_reset",    1'b0,1'b0,2'd0,1'b0,1'b0,10'd0,   1'b0, 10'd0,   1'b0,1'b0,16'd0);

        foreach (vecs[i]) begin
            rst1          = vecs[i].rst;
            bus1.Start    = vecs[i].start;
            bus1.ProgSel  = vecs[i].sel;
            bus1.BranchEn = vecs[i].ben;
            bus1.Taken    = vecs[i].tkn;
            bus1.Target   = vecs[i].tgt;
            bus1.Ack      = vecs[i].ack;
            expect_out(vecs[i].name, vecs[i].pc, vecs[i].run, vecs[i].done, vecs[i].cnt);
            step();
            sb_check(bus1.ProgCtr, bus1.Running, bus1.Done, bus1.CycleCount);
        end

        // Narrow counter: 20 RUN cycles must saturate at 15 and stay there.
        rst2 = 1'b1;
        expect_out("n_reset", 10'd0, 1'b0, 1'b0, 16'd0);
        step();
        sb_check(bus2.ProgCtr, bus2.Running, bus2.Done, {12'd0, bus2.CycleCount});
        rst2 = 1'b0;
        drive2(1'b1, 2'd0, 1'b0);
        expect_out("n_load", 10'd0, 1'b0, 1'b0, 16'd0);
        step();
        sb_check(bus2.ProgCtr, bus2.Running, bus2.Done, {12'd0, bus2.CycleCount});
        drive2(1'b0, 2'd0, 1'b0);
        expect_out("n_run", 10'd0, 1'b1, 1'b0, 16'd0);
        step();
        sb_check(bus2.ProgCtr, bus2.Running, bus2.Done, {12'd0, bus2.CycleCount});
        for (int i = 1; i <= 20; i++) begin
            expect_out($sformatf("n_sat%0d", i), 10'(i), 1'b1, 1'b0, (i > 15) ? 16'd15 : 16'(i));
            step();
            sb_check(bus2.ProgCtr, bus2.Running, bus2.Done, {12'd0, bus2.CycleCount});
        end

        // Halt the narrow instance and wait a bounded time for Done.
        drive2(1'b0, 2'd0, 1'b1);
        for (int k = 0; k < 8 && !bus2.Done; k++) begin
            step();
        end
        total++;
        if (bus2.Done !== 1'b1) begin
            bad++;
            $display("FAIL n_done_timeout: got done=%0b, want 1 within 8 cycles", bus2.Done);
        end
        drive2(1'b0, 2'd0, 1'b0);
        expect_out("n_halt", 10'd20, 1'b0, 1'b1, 16'd15);
        step();
        sb_check(bus2.ProgCtr, bus2.Running, bus2.Done, {12'd0, bus2.CycleCount});

        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL sb_leftover: got %0d pending, want 0", sb_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
